// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte-serial memory access controller that moves byte/halfword/word/doubleword
// items between a CPU-style MAR/MDR interface and an 8-bit wide byte array, big-endian.
//   clk       system clock, rising edge
//   clr       asynchronous active-low reset
//   MOV       memory operation valid; R_W 1 = read, 0 = write
//   DT        data type: 00 byte, 01 halfword, 10 word, 11 doubleword (two words)
//   address   byte base address; dataIn write data; dataOut read data (zero-extended)
//   MOC       memory operation complete (one-cycle pulse between doubleword halves)
//   memAddr/memWrData/memWE  registered byte-array write/address port; memRdData read data
//   err       misaligned-request flag, only live when MEMCTL_ALIGN_CHECK_EN is defined
module mem_access_ctrl (
    input  logic        clk,
    input  logic        clr,
    input  logic        MOV,
    input  logic        R_W,
    input  logic [1:0]  DT,
    input  logic [7:0]  address,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        MOC,
    output logic [7:0]  memAddr,
    output logic [7:0]  memWrData,
    input  logic [7:0]  memRdData,
    output logic        memWE,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, XFER, PULSE, DONE} state_t;
    state_t state, next;
    logic        rw, second, misaligned, last;
    logic [1:0]  dt, wsel, rsel;
    logic [2:0]  cnt, nbytes;
    logic [7:0]  base;
    logic [31:0] wdata;
    assign nbytes = dt == 2'b00 ? 3'd1 : dt == 2'b01 ? 3'd2 : 3'd4;
    // XFER runs one cycle longer than the byte count: cycle i issues byte i while the
    // read data of byte i-1 is captured, so the final cycle only captures.
    assign last = cnt == nbytes;
    // big-endian: byte i of an N-byte item sits at byte lane N-1-i
    assign wsel = 2'(nbytes - 3'd1 - cnt);
    assign rsel = 2'(nbytes - cnt);
    assign MOC = state == PULSE || state == DONE;
`ifdef MEMCTL_ALIGN_CHECK_EN
    assign misaligned = (DT == 2'b01 && address[0]) || (DT[1] && address[1:0] != 2'b00);
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            err <= 1'b0;
        else if (state == IDLE && MOV)
            err <= misaligned;
        else if (state == DONE && !MOV)
            err <= 1'b0;
    end
`else
    assign misaligned = 1'b0;
    assign err = 1'b0;
`endif
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            state <= IDLE;
        else
            state <= next;
    end
    always_comb begin
        next = state == IDLE  ? (MOV ? (misaligned ? DONE : XFER) : IDLE)
             : state == XFER  ? (last ? ((dt == 2'b11 && !second) ? PULSE : DONE) : XFER)
             : state == PULSE ? XFER
             : (MOV ? DONE : IDLE);
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rw        <= 1'b0;
            dt        <= 2'b00;
            base      <= 8'h00;
            wdata     <= 32'h0;
            cnt       <= 3'd0;
            second    <= 1'b0;
            dataOut   <= 32'h0;
            memAddr   <= 8'h00;
            memWrData <= 8'h00;
            memWE     <= 1'b0;
        end else begin
            memWE <= 1'b0;
            if (state == IDLE && MOV) begin
                rw      <= R_W;
                dt      <= DT;
                base    <= address;
                wdata   <= dataIn;
                cnt     <= 3'd0;
                second  <= 1'b0;
                dataOut <= 32'h0;
            end
            if (state == XFER) begin
                cnt <= last ? 3'd0 : cnt + 3'd1;
                if (!last) begin
                    memAddr   <= base + 8'(cnt) + {5'b0, second, 2'b00};
                    memWrData <= wdata[{wsel, 3'b000} +: 8];
                    memWE     <= !rw;
                end
                if (rw && cnt != 3'd0)
                    dataOut[{rsel, 3'b000} +: 8] <= memRdData;
            end
            if (state == PULSE) begin
                second <= 1'b1;
                cnt    <= 3'd0;
                if (!rw)
                    wdata <= dataIn;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with a 256-byte memory model.
module tb_mem_access_ctrl;
`ifdef MEMCTL_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        clr, MOV, R_W, memWE, MOC, err;
    logic [1:0]  DT;
    logic [7:0]  address, memAddr, memWrData, memRdData;
    logic [31:0] dataIn, dataOut;
    logic [7:0]  mem [256];
    logic [31:0] exp_q [$];
    int          wr_cnt = 0;
    int          passed = 0;
    int          total = 0;
    mem_access_ctrl dut (
        .clk(clk), .clr(clr), .MOV(MOV), .R_W(R_W), .DT(DT), .address(address),
        .dataIn(dataIn), .dataOut(dataOut), .MOC(MOC), .memAddr(memAddr),
        .memWrData(memWrData), .memRdData(memRdData), .memWE(memWE), .err(err)
    );
    always #5 clk = ~clk;
    assign memRdData = mem[memAddr];
    always @(posedge clk) begin
        if (memWE) begin
            mem[memAddr] <= memWrData;
            wr_cnt <= wr_cnt + 1;
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            passed++;
    endtask
    task automatic run_req(input string tag, input logic rw, input logic [1:0] dt,
                           input logic [7:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                           input int lat, input logic [31:0] e0, input logic [31:0] e1,
                           input logic early, input logic e_err);
        int edges;
        int w0;
        int nb;
        logic [31:0] last_exp;
        nb = dt == 2'b00 ? 1 : dt == 2'b01 ? 2 : dt == 2'b10 ? 4 : 8;
        w0 = wr_cnt;
        exp_q.push_back(e0);
        if (dt == 2'b11)
            exp_q.push_back(e1);
        @(negedge clk);
        MOV = 1'b1; R_W = rw; DT = dt; address = addr; dataIn = d0;
        @(posedge clk); #1;
        if (early)
            MOV = 1'b0;
        edges = 0;
        while (!MOC && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, ":lat"}, 32'(edges), 32'(lat));
        last_exp = exp_q.pop_front();
        chk({tag, ":data"}, dataOut, last_exp);
        if (dt == 2'b11) begin
            dataIn = d1;
            @(posedge clk); #1;
            chk({tag, ":pulse"}, {31'b0, MOC}, 32'd0);
            edges = 0;
            while (!MOC && edges < 20) begin
                @(posedge clk); #1;
                edges++;
            end
            chk({tag, ":lat2"}, 32'(edges), 32'd5);
            last_exp = exp_q.pop_front();
            chk({tag, ":data2"}, dataOut, last_exp);
        end
        chk({tag, ":err"}, {31'b0, err}, {31'b0, e_err});
        if (!early) begin
            @(posedge clk); #1;
            chk({tag, ":hold_moc"}, {31'b0, MOC}, 32'd1);
            chk({tag, ":hold_data"}, dataOut, last_exp);
            @(negedge clk);
            MOV = 1'b0;
        end
        @(posedge clk); #1;
        chk({tag, ":idle_moc"}, {31'b0, MOC}, 32'd0);
        chk({tag, ":idle_err"}, {31'b0, err}, 32'd0);
        chk({tag, ":writes"}, 32'(wr_cnt - w0), (rw || e_err) ? 32'd0 : 32'(nb));
    endtask
    initial begin
        logic [7:0] exp_bytes [8];
        logic [7:0] s0, s1;
        int n;
        clr = 1'b0; MOV = 1'b0; R_W = 1'b0; DT = 2'b00; address = 8'h00; dataIn = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_moc", {31'b0, MOC}, 32'd0);
        chk("rst_we", {31'b0, memWE}, 32'd0);
        chk("rst_addr", {24'b0, memAddr}, 32'd0);
        chk("rst_wrdata", {24'b0, memWrData}, 32'd0);
        chk("rst_dout", dataOut, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        run_req("wr_word", 1'b0, 2'b10, 8'h10, 32'hDEADBEEF, 32'h0, 5, 32'h0, 32'h0, 1'b0, 1'b0);
        exp_bytes[0] = 8'hDE; exp_bytes[1] = 8'hAD; exp_bytes[2] = 8'hBE; exp_bytes[3] = 8'hEF;
        for (int i = 0; i < 4; i++)
            chk($sformatf("mem_%0h", 8'h10 + i), {24'b0, mem[8'h10 + i]}, {24'b0, exp_bytes[i]});
        run_req("rd_word", 1'b1, 2'b10, 8'h10, 32'h0, 32'h0, 5, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        run_req("rd_byte", 1'b1, 2'b00, 8'h11, 32'h0, 32'h0, 2, 32'h000000AD, 32'h0, 1'b0, 1'b0);
        run_req("rd_half_early", 1'b1, 2'b01, 8'h12, 32'h0, 32'h0, 3, 32'h0000BEEF, 32'h0, 1'b1, 1'b0);
        run_req("wr_dword", 1'b0, 2'b11, 8'h20, 32'h11223344, 32'h55667788, 5, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            exp_bytes[i] = 8'(8'h11 * (i + 1));
        for (int i = 0; i < 8; i++)
            chk($sformatf("mem_%0h", 8'h20 + i), {24'b0, mem[8'h20 + i]}, {24'b0, exp_bytes[i]});
        run_req("rd_dword", 1'b1, 2'b11, 8'h20, 32'h0, 32'h0, 5, 32'h11223344, 32'h55667788, 1'b0, 1'b0);
        s0 = mem[8'hFF];
        s1 = mem[8'h00];
        run_req("wr_half_ff", 1'b0, 2'b01, 8'hFF, 32'h0000ABCD, 32'h0, ALIGN ? 0 : 3, 32'h0, 32'h0, 1'b0, ALIGN);
        chk("mem_ff", {24'b0, mem[8'hFF]}, {24'b0, ALIGN ? s0 : 8'hAB});
        chk("mem_00", {24'b0, mem[8'h00]}, {24'b0, ALIGN ? s1 : 8'hCD});
        s0 = mem[8'h42];
        s1 = mem[8'h43];
        @(negedge clk);
        MOV = 1'b1; R_W = 1'b0; DT = 2'b10; address = 8'h40; dataIn = 32'h01020304;
        n = 0;
        while (!(memWE && memAddr == 8'h42) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_mid_reach", {31'b0, memWE && memAddr == 8'h42}, 32'd1);
        clr = 1'b0;
        #1;
        chk("rst_mid_moc", {31'b0, MOC}, 32'd0);
        chk("rst_mid_we", {31'b0, memWE}, 32'd0);
        chk("rst_mid_addr", {24'b0, memAddr}, 32'd0);
        MOV = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        chk("rst_mem_40", {24'b0, mem[8'h40]}, 32'h01);
        chk("rst_mem_41", {24'b0, mem[8'h41]}, 32'h02);
        chk("rst_mem_42", {24'b0, mem[8'h42]}, {24'b0, s0});
        chk("rst_mem_43", {24'b0, mem[8'h43]}, {24'b0, s1});
        run_req("after_rst", 1'b1, 2'b00, 8'h41, 32'h0, 32'h0, 2, 32'h00000002, 32'h0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state changes on rising edge.
REQ-002 SHALL have port clr, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port MOV, input, 1, memory operation valid from the control unit.
REQ-004 SHALL have port R_W, input, 1, 1 = read, 0 = write.
REQ-005 SHALL have port DT, input, 2, data type: 00 byte, 01 halfword, 10 word, 11 doubleword.
REQ-006 SHALL have port address, input, 8, byte address from MAR.
REQ-007 SHALL have port dataIn, input, 32, write data from MDR.
REQ-008 SHALL have port dataOut, output, 32, read data to the instruction register and MDR path.
REQ-009 SHALL have port MOC, output, 1, memory operation complete.
REQ-010 SHALL have port memAddr, output, 8, byte-array address.
REQ-011 SHALL have port memWrData, output, 8, byte write data.
REQ-012 SHALL have port memRdData, input, 8, byte read data, combinational from memAddr.
REQ-013 SHALL have port memWE, output, 1, byte write strobe, one byte per cycle.
REQ-014 SHALL have port err, output, 1, misaligned-request flag (see REQ-031).

Function
REQ-015 SHALL implement FSM states IDLE, XFER, PULSE, DONE.
REQ-016 In IDLE, MOV=1 at a rising edge SHALL latch R_W, DT, address, and dataIn (for writes), clear the byte counter, and enter XFER.
REQ-017 Byte count N SHALL be 1, 2, or 4 for DT 00/01/10; DT 11 SHALL run two 4-byte words.
REQ-018 In XFER, each cycle SHALL drive memAddr = base + i, modulo 256 (0xFF+1 wraps to 0x00), for i = 0..N-1.
REQ-019 Byte order SHALL be big-endian: i = 0 is the most significant byte of the item.
REQ-020 Writes in XFER SHALL assert memWE with memWrData = item byte i; reads SHALL capture memRdData into the item byte i of dataOut at the cycle's edge.
REQ-021 Byte and halfword reads SHALL zero-extend into dataOut; unaccessed dataOut bits SHALL read 0.
REQ-022 After the last byte, the FSM SHALL enter DONE with MOC=1, which is N+1 rising edges after the accepting edge (word: 5).
REQ-023 DONE SHALL hold MOC=1 and dataOut stable until MOV is sampled 0, then return to IDLE with MOC=0.
REQ-024 For DT 11, after the first word the FSM SHALL enter PULSE: MOC=1 for exactly one cycle with word 0 on dataOut.
REQ-025 For DT 11 writes, dataIn SHALL be re-latched at the edge leaving PULSE.
REQ-026 For DT 11, the second word SHALL then transfer at base+4 (with wrap), ending in DONE.
REQ-027 If MOV drops during XFER or PULSE, the transfer SHALL still complete; DONE SHALL then assert MOC for one cycle only before IDLE.
REQ-028 memWE SHALL be 0 in every state other than XFER; a new request SHALL be accepted only in IDLE.

Reset
REQ-029 clr=0 SHALL immediately force the state to IDLE and zero MOC, memWE, memAddr, memWrData, dataOut, err, and the counter, regardless of state.
REQ-030 A reset mid-transfer SHALL abandon the transfer with no further memWE; bytes already written remain written.

Configuration
REQ-031 With macro MEMCTL_ALIGN_CHECK_EN defined, a misaligned request (halfword address[0]=1; word or doubleword address[1:0]!=0) SHALL skip XFER with no memWE and go to DONE with err=1 and dataOut=0; err SHALL clear on return to IDLE.
REQ-032 Without MEMCTL_ALIGN_CHECK_EN, err SHALL be tied 0 and misaligned addresses SHALL be accessed as given, with wrap.

Verification
REQ-033 Write word 0xDEADBEEF at 0x10, then read word 0x10: bytes 0x10..0x13 = DE AD BE EF; dataOut = 0xDEADBEEF; MOC 5 edges after accept.
REQ-034 Read byte at 0x11 after REQ-033: dataOut = 0x000000AD; MOC 2 edges after accept.
REQ-035 Doubleword write 0x11223344 then 0x55667788 at 0x20: one-cycle MOC pulse between words; bytes 0x20..0x27 = 11 22 33 44 55 66 77 88.
REQ-036 Halfword write 0xABCD at 0xFF (macro off): mem[0xFF]=AB, mem[0x00]=CD; with macro on: err=1, no memWE, MOC asserted.
REQ-037 Assert clr=0 at byte 2 of a word write: MOC and memWE drop immediately; only the first two bytes are modified; the next request completes normally.
